adder_arbiter: RTL and testbench

Shares the single 8-bit FullAdder datapath of the RISC CPU between up to NREQ requesters (e.g. PC-increment, address-generation, ALU, debug port). Each requester presents an operand pair with a valid/ready handshake. A round-robin grant selects one request at a time and drives the shared adder's InA/InB from registered operands. The block captures the adder's S into a result register and returns it with the requester ID under a valid/ready response handshake.

---
 rtl/adder_arbiter_if.sv | 38 +++
 rtl/adder_arbiter.sv | 125 ++++++++++++
 tb/tb_adder_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adder_arbiter_if
// Brief    : Request, shared-adder and response signals of adder_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       ReqValid;
  logic [NREQ*WIDTH-1:0] ReqA;
  logic [NREQ*WIDTH-1:0] ReqB;
  logic [NREQ-1:0]       ReqReady;
  logic [WIDTH-1:0]      AddA;
  logic [WIDTH-1:0]      AddB;
  logic [WIDTH-1:0]      AddS;
  logic                  RspValid;
  logic [WIDTH-1:0]      RspData;
  logic [IDW-1:0]        RspId;
  logic                  RspReady;
  logic                  Busy;

  // Arbiter side
  modport slave (
    input  ReqValid, ReqA, ReqB, AddS, RspReady,
    output ReqReady, AddA, AddB, RspValid, RspData, RspId, Busy
  );

  // Requesters, shared adder and response consumer
  modport master (
    output ReqValid, ReqA, ReqB, AddS, RspReady,
    input  ReqReady, AddA, AddB, RspValid, RspData, RspId, Busy
  );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin arbiter sharing one adder between NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  adder_arbiter_if.slave  bus
);

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             found;
  logic [IDW-1:0]   grant;
  logic [IDW:0]     rr_idx;
  logic [WIDTH-1:0] req_a [NREQ];
  logic [WIDTH-1:0] req_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_a[i] = bus.ReqA[i*WIDTH +: WIDTH];
    assign req_b[i] = bus.ReqB[i*WIDTH +: WIDTH];
  end

  // First valid requester at or above ptr_q, wrapping modulo NREQ
  always_comb begin
    found  = 1'b0;
    grant  = '0;
    rr_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (rr_idx >= NREQ_W) begin
        rr_idx = rr_idx - NREQ_W;
      end
      if (!found && bus.ReqValid[rr_idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = rr_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          opa_d   = req_a[grant];
          opb_d   = req_b[grant];
          id_d    = grant;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        rsp_data_d  = bus.AddS;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.RspReady) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.ReqReady = (state_q == ST_IDLE && found) ? (NREQ'(1) << grant) : '0;
  assign bus.AddA     = opa_q;
  assign bus.AddB     = opb_q;
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspData  = rsp_data_q;
  assign bus.RspId    = id_q;
  assign bus.Busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adder_arbiter
// Brief    : Self-checking bench for adder_arbiter with round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus();

  // The shared adder lives outside the arbiter
  assign bus.AddS = bus.AddA + bus.AddB;

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int model_ptr = 0;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.ReqReady), 0);
    check({tag, "_adda"},  32'(bus.AddA), 0);
    check({tag, "_addb"},  32'(bus.AddB), 0);
    check({tag, "_valid"}, 32'(bus.RspValid), 0);
    check({tag, "_data"},  32'(bus.RspData), 0);
    check({tag, "_id"},    32'(bus.RspId), 0);
    check({tag, "_busy"},  32'(bus.Busy), 0);
  endtask

  // One complete transaction; operands of other requesters are randomized
  task automatic txn(input logic [NREQ-1:0] valid, input int exp_g,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] exp_s, input int delay);
    logic [NREQ-1:0] exp_rdy;
    exp_rdy        = '0;
    exp_rdy[exp_g] = 1'b1;
    bus.ReqA = 32'($urandom);
    bus.ReqB = 32'($urandom);
    bus.ReqA[exp_g*WIDTH +: WIDTH] = a;
    bus.ReqB[exp_g*WIDTH +: WIDTH] = b;
    bus.ReqValid = valid;
    bus.RspReady = (delay == 0);
    #2;
    check("accept_ready", 32'(bus.ReqReady), 32'(exp_rdy));
    check("idle_busy", 32'(bus.Busy), 0);
    @(posedge clk); #1;
    bus.ReqA     = 32'($urandom);
    bus.ReqB     = 32'($urandom);
    bus.ReqValid = NREQ'($urandom);
    #1;
    check("add_ready", 32'(bus.ReqReady), 0);
    check("add_busy", 32'(bus.Busy), 1);
    check("add_rspvalid", 32'(bus.RspValid), 0);
    check("add_opa", 32'(bus.AddA), 32'(a));
    check("add_opb", 32'(bus.AddB), 32'(b));
    @(posedge clk); #2;
    for (int c = 0; c <= delay; c++) begin
      check("rsp_valid", 32'(bus.RspValid), 1);
      check("rsp_data", 32'(bus.RspData), 32'(exp_s));
      check("rsp_id", 32'(bus.RspId), exp_g);
      check("rsp_ready", 32'(bus.ReqReady), 0);
      check("rsp_busy", 32'(bus.Busy), 1);
      if (c == delay) bus.RspReady = 1'b1;
      @(posedge clk); #1;
    end
    bus.RspReady = 1'b0;
    bus.ReqValid = '0;
    #1;
    check("done_valid", 32'(bus.RspValid), 0);
    check("done_busy", 32'(bus.Busy), 0);
    model_ptr = (exp_g + 1) % NREQ;
  endtask

  initial begin
    vecs[0] = '{2'd0, 8'h12, 8'h34, 8'h46};
    vecs[1] = '{2'd2, 8'hFF, 8'h01, 8'h00};
    vecs[2] = '{2'd2, 8'h80, 8'h80, 8'h00};
    vecs[3] = '{2'd1, 8'h7F, 8'h01, 8'h80};
    vecs[4] = '{2'd3, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{2'd3, 8'hFF, 8'hFF, 8'hFE};

    bus.ReqValid = '0;
    bus.ReqA     = '0;
    bus.ReqB     = '0;
    bus.RspReady = 1'b0;

    // Reset: clock edges must not disturb the zeroed outputs
    #22;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    check("post_reset_ready", 32'(bus.ReqReady), 0);
    check("post_reset_busy", 32'(bus.Busy), 0);

    // Round-robin with all requesters asserting: grants 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      logic [WIDTH-1:0] a, b;
      a = WIDTH'(8'h10 * (k + 1));
      b = WIDTH'(k + 3);
      txn(4'hF, k % NREQ, a, b, a + b, 0);
    end

    // Table of single-requester vectors, including carry wrap-around
    for (int i = 0; i < 6; i++) begin
      txn(NREQ'(1) << vecs[i].id, int'(vecs[i].id), vecs[i].a, vecs[i].b, vecs[i].s, 0);
    end

    // Backpressure for 5 cycles
    txn(4'b0100, 2, 8'h5A, 8'h0F, 8'h69, 5);

    // Reset mid-operation while in RESP holding 0x46; ptr was 1 before reset
    txn(4'b0001, 0, 8'h01, 8'h02, 8'h03, 0);
    bus.ReqA[0 +: WIDTH] = 8'h12;
    bus.ReqB[0 +: WIDTH] = 8'h34;
    bus.ReqValid = 4'b0001;
    bus.RspReady = 1'b0;
    @(posedge clk); #1;
    bus.ReqValid = '0;
    @(posedge clk); #2;
    check("midop_data", 32'(bus.RspData), 32'h46);
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_async");
    @(posedge clk); #1;
    check("midop_hold_valid", 32'(bus.RspValid), 0);
    check("midop_hold_busy", 32'(bus.Busy), 0);
    @(negedge clk) rst_n = 1'b1;
    model_ptr = 0;
    @(posedge clk); #1;
    txn(4'b0011, 0, 8'h21, 8'h22, 8'h43, 0);

    // Randomized traffic against the round-robin reference model
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] v;
      int a, b, d;
      v = NREQ'($urandom_range(0, 15));
      if (it % 5 == 4) v = '0;
      if (v == '0) begin
        bus.ReqValid = '0;
        bus.ReqA     = 32'($urandom);
        #2;
        check("idle_noreq_ready", 32'(bus.ReqReady), 0);
        check("idle_noreq_busy", 32'(bus.Busy), 0);
        @(posedge clk); #1;
      end else begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        d = int'($urandom_range(0, 3));
        txn(v, rr_grant(v, model_ptr), WIDTH'(a), WIDTH'(b), WIDTH'((a + b) % 256), d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
